// File: rtl/dm_pkg.sv
// Shared constants, write-mask presets and the clear-sequencer state type for the
// LSU data-memory responder.
package dm_pkg;

  localparam int          DM_WORD_W    = 32;
  localparam logic [31:0] DM_MASK_NONE = 32'hFFFF_FFFF;

  // Active-low write masks: a 0 bit selects that bit for writing.
  localparam logic [31:0] DM_MASK_B0 = 32'hFFFF_FF00;
  localparam logic [31:0] DM_MASK_B1 = 32'hFFFF_00FF;
  localparam logic [31:0] DM_MASK_B2 = 32'hFF00_FFFF;
  localparam logic [31:0] DM_MASK_B3 = 32'h00FF_FFFF;
  localparam logic [31:0] DM_MASK_H0 = 32'hFFFF_0000;
  localparam logic [31:0] DM_MASK_H1 = 32'h0000_FFFF;

  typedef enum logic {DM_CLEAR, DM_READY} dm_state_e;

  function automatic logic [DM_WORD_W-1:0] dm_merge(
    input logic [DM_WORD_W-1:0] old_word,
    input logic [DM_WORD_W-1:0] new_data,
    input logic [DM_WORD_W-1:0] mask_n
  );
    return (old_word & mask_n) | (new_data & ~mask_n);
  endfunction

endpackage

// File: rtl/dm_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then parks in READY and
// raises dm_ready from a register.
module dm_clear_seq
  import dm_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_idx,
  output logic                     dm_ready
);

  localparam int AW = $clog2(DEPTH);

  dm_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= DM_CLEAR;
      else                state_q <= DM_READY;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == DM_READY);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      DM_CLEAR: begin
        clr_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = DM_READY;
      end
      default: ;
    endcase
  end

  assign clr_idx  = idx_q;
  assign dm_ready = ready_q;

endmodule

// File: rtl/data_mem_responder.sv
// LSU data-memory responder: word RAM with 1-cycle registered reads, bit-masked writes,
// access counters and an optional first-fault log (enabled by DM_FAULT_LOG_EN).
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH          = 1024,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  output logic        dm_ready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        fault_is_wr,
  input  logic        fault_clr
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  logic [DM_WORD_W-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          ready;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_req, rd_fire, rd_hit, wr_hit, oor_hit;

  logic [31:0]   rd_data_q, rd_cnt_q, wr_cnt_q;

  dm_clear_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .dm_ready (ready)
  );

  // Unsigned subtract makes addresses below the base wrap high and fall out of range.
  assign off      = DM_addr - ADDR_BASE;
  assign in_range = (off < SPAN);
  assign idx      = off[AW+1:2];

  assign wr_req  = !DM_r_en && (DM_w_en != DM_MASK_NONE);
  assign rd_fire = ready && DM_r_en;
  assign rd_hit  = rd_fire && in_range;
  assign wr_hit  = ready && wr_req && in_range;
  assign oor_hit = ready && (DM_r_en || wr_req) && !in_range;

  // Storage has no reset; the sweep owns the write port until dm_ready.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_idx] <= '0;
    else if (wr_hit) mem[idx]     <= dm_merge(mem[idx], DM_w_data, DM_w_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_hit) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_hit) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign DM_rd_data = rd_data_q;
  assign dm_ready   = ready;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

`ifdef DM_FAULT_LOG_EN
  logic        fault_valid_q;
  logic [31:0] fault_addr_q;
  logic        fault_is_wr_q;

  // Only the first fault is kept; a same-cycle clear wins over a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_is_wr_q <= 1'b0;
    end else if (fault_clr) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_is_wr_q <= 1'b0;
    end else if (oor_hit && !fault_valid_q) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= DM_addr;
      fault_is_wr_q <= !DM_r_en;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_is_wr = fault_is_wr_q;
`else
  logic unused_fault;
  assign unused_fault = fault_clr ^ oor_hit;

  assign fault_valid = 1'b0;
  assign fault_addr  = '0;
  assign fault_is_wr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder (DEPTH=16, ADDR_BASE=0x1000); fault
// expectations follow DM_FAULT_LOG_EN.
module tb_data_mem_responder;
  import dm_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DM_r_en = 1'b0;
  logic [31:0] DM_w_en = 32'hFFFF_FFFF;
  logic [31:0] DM_addr = 32'h0000_1000;
  logic [31:0] DM_w_data = 32'h0;
  logic [31:0] DM_rd_data;
  logic        dm_ready;
  logic [31:0] rd_cnt, wr_cnt;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_is_wr;
  logic        fault_clr = 1'b0;

  data_mem_responder #(
    .DEPTH          (DEPTH),
    .ADDR_BASE      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DM_r_en     (DM_r_en),
    .DM_w_en     (DM_w_en),
    .DM_addr     (DM_addr),
    .DM_w_data   (DM_w_data),
    .DM_rd_data  (DM_rd_data),
    .dm_ready    (dm_ready),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_is_wr (fault_is_wr),
    .fault_clr   (fault_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ntx    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory contents and the externally visible state after each cycle.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_last, m_rdc, m_wrc, m_fa;
  logic        m_fv, m_fw;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] rc;
    logic [31:0] wc;
    logic        fv;
    logic [31:0] fa;
    logic        fw;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_last = 0; m_rdc = 0; m_wrc = 0; m_fv = 0; m_fa = 0; m_fw = 0;
  endtask

  // One request cycle: drive at the falling edge, predict the post-edge state.
  task automatic do_req(input logic r, input logic [31:0] m, input logic [31:0] a,
                        input logic [31:0] d, input logic clr);
    logic [31:0] off;
    bit          inr;
    bit          hit;
    int          w;
    exp_t        x;
    @(negedge clk);
    DM_r_en = r; DM_w_en = m; DM_addr = a; DM_w_data = d; fault_clr = clr;
    off = a - BASE;
    inr = (off < 32'(DEPTH * 4));
    w   = int'(off >> 2);
    hit = r || (m != 32'hFFFF_FFFF);
`ifdef DM_FAULT_LOG_EN
    if (hit && !inr && !m_fv) begin m_fv = 1; m_fa = a; m_fw = !r; end
    if (clr) begin m_fv = 0; m_fa = 0; m_fw = 0; end
`else
    if (hit && clr) begin end
`endif
    if (r) begin
      m_last = inr ? m_mem[w] : 32'h0;
      if (inr) m_rdc++;
    end else if (hit && inr) begin
      for (int b = 0; b < 32; b++) if (m[b] == 1'b0) m_mem[w][b] = d[b];
      m_wrc++;
    end
    x.is_rd = r; x.addr = a; x.rd = m_last; x.rc = m_rdc; x.wc = m_wrc;
    x.fv = m_fv; x.fa = m_fa; x.fw = m_fw;
    sb_q.push_back(x);
  endtask

  task automatic idle();
    do_req(1'b0, DM_MASK_NONE, BASE, 32'h0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk); #3;
  endtask

  task automatic drain();
    for (int g = 0; g < 5 && sb_q.size() != 0; g++) settle();
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every honoured cycle the DUT state must match the scoreboard entry.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        ntx++;
        chk("rd_data",     DM_rd_data,        e.rd);
        chk("rd_cnt",      rd_cnt,            e.rc);
        chk("wr_cnt",      wr_cnt,            e.wc);
        chk("fault_valid", 32'(fault_valid),  32'(e.fv));
        chk("fault_addr",  fault_addr,        e.fa);
        chk("fault_is_wr", 32'(fault_is_wr),  32'(e.fw));
        chk("dm_ready",    32'(dm_ready),     32'd1);
        $display("txn %0d %s addr=%h rd_data=%h rd_cnt=%0d wr_cnt=%0d fv=%0b",
                 ntx, e.is_rd ? "RD" : "WR", e.addr, DM_rd_data, rd_cnt, wr_cnt, fault_valid);
      end
    end
  end

  // Counts edges from reset release to dm_ready while random requests hit the sweep.
  task automatic sweep_count(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      DM_r_en   = 1'($urandom_range(0, 1));
      DM_w_en   = $urandom;
      DM_addr   = BASE + 32'($urandom_range(0, 127));
      DM_w_data = $urandom;
      fault_clr = 1'b0;
      @(posedge clk); #1;
      n++;
      if (dm_ready) break;
      chk({name, "_sweep_rd"}, DM_rd_data, 32'h0);
      @(negedge clk);
    end
    DM_r_en = 1'b0; DM_w_en = DM_MASK_NONE;
    chk({name, "_sweep_len"}, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m, a;
    model_reset();

    // Test 1: reset state, sweep length, requests ignored during the sweep.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   32'(dm_ready), 32'd0);
    chk("rst_rd_data", DM_rd_data,    32'h0);
    chk("rst_rd_cnt",  rd_cnt,        32'h0);
    @(negedge clk); rst = 1'b0;
    sweep_count("t1");
    chk("t1_wr_cnt", wr_cnt, 32'h0);
    chk("t1_rd_cnt", rd_cnt, 32'h0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h3C, 32'h0, 1'b0);
    settle();
    chk("t1_rd_3c", DM_rd_data, 32'h0);

    // Test 2: full-word write then immediate read-back.
    do_req(1'b0, 32'h0, BASE + 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h10, 32'h0, 1'b0);
    settle();
    chk("t2_rd",     DM_rd_data, 32'hDEADBEEF);
    chk("t2_wr_cnt", wr_cnt,     32'd1);
    chk("t2_rd_cnt", rd_cnt,     32'd2);

    // Test 3: byte-lane and half-word merges.
    do_req(1'b0, DM_MASK_B1, BASE + 32'h11, 32'h0000AA00, 1'b0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h10, 32'h0, 1'b0);
    settle();
    chk("t3_sb", DM_rd_data, 32'hDEADAAEF);
    do_req(1'b0, DM_MASK_H1, BASE + 32'h12, 32'h12340000, 1'b0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h10, 32'h0, 1'b0);
    settle();
    chk("t3_sh", DM_rd_data, 32'h1234AAEF);

    // Test 4: all-ones mask is a no-op; idle cycles hold the read data.
    do_req(1'b0, DM_MASK_NONE, BASE + 32'h10, 32'hFFFFFFFF, 1'b0);
    settle();
    chk("t4_hold", DM_rd_data, 32'h1234AAEF);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h10, 32'h0, 1'b0);
    settle();
    chk("t4_rd",     DM_rd_data,         32'h1234AAEF);
    chk("t4_wr_cnt", wr_cnt,             32'd3);
    chk("t4_fv",     32'(fault_valid),   32'd0);

    // Test 5: out-of-range accesses and fault logging.
    do_req(1'b1, DM_MASK_NONE, 32'h0000_0FFC, 32'h0, 1'b0);
    settle();
    chk("t5_rd_oor", DM_rd_data, 32'h0);
    chk("t5_rd_cnt", rd_cnt,     32'd5);
`ifdef DM_FAULT_LOG_EN
    chk("t5_fv", 32'(fault_valid), 32'd1);
    chk("t5_fa", fault_addr,       32'h0000_0FFC);
    chk("t5_fw", 32'(fault_is_wr), 32'd0);
`else
    chk("t5_fv", 32'(fault_valid), 32'd0);
`endif
    do_req(1'b0, 32'h0, 32'h0000_2000, 32'h55555555, 1'b0);
    settle();
    chk("t5_wr_cnt", wr_cnt, 32'd3);
`ifdef DM_FAULT_LOG_EN
    chk("t5_fa_keep", fault_addr,       32'h0000_0FFC);
    chk("t5_fw_keep", 32'(fault_is_wr), 32'd0);
`else
    chk("t5_fa_keep", fault_addr, 32'h0);
`endif
    do_req(1'b0, DM_MASK_NONE, BASE, 32'h0, 1'b1);
    settle();
    chk("t5_clr_fv", 32'(fault_valid), 32'd0);
    chk("t5_clr_fa", fault_addr,       32'h0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 240; k++) begin
      case ($urandom_range(0, 9))
        0:       m = 32'h0;
        1:       m = DM_MASK_B0;
        2:       m = DM_MASK_B1;
        3:       m = DM_MASK_B2;
        4:       m = DM_MASK_B3;
        5:       m = DM_MASK_H0;
        6:       m = DM_MASK_H1;
        7:       m = DM_MASK_NONE;
        default: m = $urandom;
      endcase
      case ($urandom_range(0, 11))
        0:       a = BASE - 32'($urandom_range(1, 64));
        1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      do_req(1'($urandom_range(0, 1)), m, a, $urandom, 1'($urandom_range(0, 15) == 0));
    end

    // Test 6: async reset with live data, then a reset in mid-sweep.
    do_req(1'b0, 32'h0, BASE + 32'h20, 32'hA5A55A5A, 1'b0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h20, 32'h0, 1'b0);
    idle();
    drain();
    chk("t6_pre_rd", DM_rd_data, 32'hA5A55A5A);
    rst = 1'b1;
    #1;
    chk("t6_async_rd",    DM_rd_data,      32'h0);
    chk("t6_async_ready", 32'(dm_ready),   32'd0);
    chk("t6_async_rdcnt", rd_cnt,          32'h0);
    chk("t6_async_wrcnt", wr_cnt,          32'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    DM_r_en = 1'b0; DM_w_en = DM_MASK_NONE; fault_clr = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_mid_ready", 32'(dm_ready), 32'd0);
    chk("t6_mid_rd",    DM_rd_data,    32'h0);
    @(negedge clk); rst = 1'b0;
    sweep_count("t6");
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h20, 32'h0, 1'b0);
    settle();
    chk("t6_cleared_20", DM_rd_data, 32'h0);
    do_req(1'b1, DM_MASK_NONE, BASE + 32'h10, 32'h0, 1'b0);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
